pos_sweep_ctrl: RTL and testbench

- Sequencer that drives the three select inputs X, Y, Z of a 3-input sum/product-of-terms logic block through all 8 minterms, index 0..7, with X as the MSB.
- Samples two implementations of the same function: S1, the unsimplified maxterm form, and S2, the simplified form.
- Captures both truth tables and flags any minterm where they disagree.
- Sits beside the combinational function block as its self-check controller, replacing stimulus-only benches with a synthesizable equivalence sweep.

---
 rtl/pos_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_pos_sweep_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_sweep_ctrl.sv
// Equivalence sweep controller: walks X/Y/Z through all 8 minterms,
// captures both function outputs into truth tables and flags disagreements.
module pos_sweep_ctrl #(
    parameter int unsigned SETTLE      = 1,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       S1,
    input  logic       S2,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt1,
    output logic [7:0] tt2,
    output logic [7:0] mismatch,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [3:0] cnt, cnt_n;
    logic       busy_n, done_n, err_n;
    logic [7:0] tt1_n, tt2_n;
    logic [3:0] err_cnt_n;
    logic [2:0] first_err_n;
    logic       diff;

    assign diff     = S1 ^ S2;
    assign mismatch = tt1 ^ tt2;
    assign X        = idx[2];
    assign Y        = idx[1];
    assign Z        = idx[0];

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        busy_n      = busy;
        done_n      = 1'b0;
        tt1_n       = tt1;
        tt2_n       = tt2;
        err_cnt_n   = err_cnt;
        first_err_n = first_err;
        err_n       = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    tt1_n       = '0;
                    tt2_n       = '0;
                    err_cnt_n   = '0;
                    first_err_n = '0;
                    err_n       = 1'b0;
                    idx_n       = '0;
                    cnt_n       = RELOAD;
                    busy_n      = 1'b1;
                    state_n     = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    tt1_n[idx] = S1;
                    tt2_n[idx] = S2;
                    if (diff) begin
                        err_cnt_n = err_cnt + 4'd1;
                        if (!err) begin
                            first_err_n = idx;
                            err_n       = 1'b1;
                        end
                    end
                    if (idx == 3'd7 || (STOP_ON_ERR && diff)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 3'd1;
                        cnt_n = RELOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt1       <= '0;
            tt2       <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            tt1       <= tt1_n;
            tt2       <= tt2_n;
            err_cnt   <= err_cnt_n;
            first_err <= first_err_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// Bench for pos_sweep_ctrl: three configurations, vector table,
// random truth tables against a minterm-loop model, and corner sequences.
module tb_pos_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start_w [3];
    logic       s1_w    [3];
    logic       s2_w    [3];
    logic       x_w     [3];
    logic       y_w     [3];
    logic       z_w     [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] tt1_w   [3];
    logic [7:0] tt2_w   [3];
    logic [7:0] mm_w    [3];
    logic [3:0] ec_w    [3];
    logic [2:0] fe_w    [3];
    logic       err_w   [3];
    logic [7:0] f1_t    [3];
    logic [7:0] f2_t    [3];

    int total = 0;
    int bad   = 0;

    pos_sweep_ctrl #(.SETTLE(1), .STOP_ON_ERR(1'b0)) u0 (
        .clk(clk), .reset(reset), .start(start_w[0]),
        .S1(s1_w[0]), .S2(s2_w[0]),
        .X(x_w[0]), .Y(y_w[0]), .Z(z_w[0]),
        .busy(busy_w[0]), .done(done_w[0]),
        .tt1(tt1_w[0]), .tt2(tt2_w[0]), .mismatch(mm_w[0]),
        .err_cnt(ec_w[0]), .first_err(fe_w[0]), .err(err_w[0])
    );

    pos_sweep_ctrl #(.SETTLE(1), .STOP_ON_ERR(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start_w[1]),
        .S1(s1_w[1]), .S2(s2_w[1]),
        .X(x_w[1]), .Y(y_w[1]), .Z(z_w[1]),
        .busy(busy_w[1]), .done(done_w[1]),
        .tt1(tt1_w[1]), .tt2(tt2_w[1]), .mismatch(mm_w[1]),
        .err_cnt(ec_w[1]), .first_err(fe_w[1]), .err(err_w[1])
    );

    pos_sweep_ctrl #(.SETTLE(3), .STOP_ON_ERR(1'b0)) u2 (
        .clk(clk), .reset(reset), .start(start_w[2]),
        .S1(s1_w[2]), .S2(s2_w[2]),
        .X(x_w[2]), .Y(y_w[2]), .Z(z_w[2]),
        .busy(busy_w[2]), .done(done_w[2]),
        .tt1(tt1_w[2]), .tt2(tt2_w[2]), .mismatch(mm_w[2]),
        .err_cnt(ec_w[2]), .first_err(fe_w[2]), .err(err_w[2])
    );

    // Function blocks modelled as truth-table lookups on the applied minterm
    for (genvar g = 0; g < 3; g++) begin : g_fb
        assign s1_w[g] = f1_t[g][{x_w[g], y_w[g], z_w[g]}];
        assign s2_w[g] = f2_t[g][{x_w[g], y_w[g], z_w[g]}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] xyz(input int k);
        return {x_w[k], y_w[k], z_w[k]};
    endfunction

    task automatic chk_rst(input int k, input string nm);
        chk({nm, ".busy"}, 32'(busy_w[k]), 0);
        chk({nm, ".done"}, 32'(done_w[k]), 0);
        chk({nm, ".tt1"}, 32'(tt1_w[k]), 0);
        chk({nm, ".tt2"}, 32'(tt2_w[k]), 0);
        chk({nm, ".mm"}, 32'(mm_w[k]), 0);
        chk({nm, ".ec"}, 32'(ec_w[k]), 0);
        chk({nm, ".fe"}, 32'(fe_w[k]), 0);
        chk({nm, ".err"}, 32'(err_w[k]), 0);
        chk({nm, ".xyz"}, 32'(xyz(k)), 0);
    endtask

    // Reference: visit minterms in order, stop early only when asked
    function automatic void model(input logic [7:0] f1, input logic [7:0] f2,
                                  input bit stop,
                                  output logic [7:0] t1, output logic [7:0] t2,
                                  output int ec, output int fe,
                                  output int e, output int nv);
        t1 = '0; t2 = '0; ec = 0; fe = 0; e = 0; nv = 0;
        for (int i = 0; i < 8; i++) begin
            t1[i] = f1[i];
            t2[i] = f2[i];
            nv = i + 1;
            if (f1[i] != f2[i]) begin
                if (ec == 0) fe = i;
                ec++;
                e = 1;
                if (stop) break;
            end
        end
    endfunction

    task automatic sweep(input int k, input logic [7:0] f1,
                         input logic [7:0] f2, input logic [7:0] e_t1,
                         input logic [7:0] e_t2, input logic [7:0] e_mm,
                         input int e_ec, input int e_fe, input int e_err,
                         input int e_lat, input int e_xyz, input int rp,
                         input string nm);
        int c;
        int st;
        bit got;
        st = (k == 2) ? 3 : 1;
        f1_t[k] = f1;
        f2_t[k] = f2;
        @(negedge clk);
        start_w[k] = 1'b1;
        @(negedge clk);
        start_w[k] = 1'b0;
        c = 0;
        got = 1'b0;
        while (c < 200) begin
            if (done_w[k]) begin
                got = 1'b1;
                break;
            end
            chk({nm, ".hold"}, 32'(xyz(k)), 32'(c / st));
            chk({nm, ".busy"}, 32'(busy_w[k]), 1);
            start_w[k] = (c == rp);
            @(negedge clk);
            c++;
        end
        start_w[k] = 1'b0;
        chk({nm, ".done_seen"}, 32'(got), 1);
        chk({nm, ".latency"}, 32'(c), 32'(e_lat));
        chk({nm, ".busy_end"}, 32'(busy_w[k]), 0);
        chk({nm, ".tt1"}, 32'(tt1_w[k]), 32'(e_t1));
        chk({nm, ".tt2"}, 32'(tt2_w[k]), 32'(e_t2));
        chk({nm, ".mm"}, 32'(mm_w[k]), 32'(e_mm));
        chk({nm, ".ec"}, 32'(ec_w[k]), 32'(e_ec));
        chk({nm, ".fe"}, 32'(fe_w[k]), 32'(e_fe));
        chk({nm, ".err"}, 32'(err_w[k]), 32'(e_err));
        chk({nm, ".xyz"}, 32'(xyz(k)), 32'(e_xyz));
        @(negedge clk);
        chk({nm, ".done_pulse"}, 32'(done_w[k]), 0);
        chk({nm, ".tt1_hold"}, 32'(tt1_w[k]), 32'(e_t1));
        chk({nm, ".xyz_hold"}, 32'(xyz(k)), 32'(e_xyz));
    endtask

    typedef struct {
        int         k;
        logic [7:0] f1;
        logic [7:0] f2;
        logic [7:0] t1;
        logic [7:0] t2;
        logic [7:0] mm;
        int         ec;
        int         fe;
        int         er;
        int         lat;
        int         xyz;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [7:0] f1, f2, t1, t2;
        int ec, fe, e, nv, k, c;
        bit seen;

        vt[0] = '{0, 8'h3B, 8'h3B, 8'h3B, 8'h3B, 8'h00, 0, 0, 0, 8, 7};
        vt[1] = '{0, 8'h3B, 8'hFF, 8'h3B, 8'hFF, 8'hC4, 3, 2, 1, 8, 7};
        vt[2] = '{1, 8'h3B, 8'hFF, 8'h03, 8'h07, 8'h04, 1, 2, 1, 3, 2};
        vt[3] = '{2, 8'h3B, 8'h3B, 8'h3B, 8'h3B, 8'h00, 0, 0, 0, 24, 7};
        vt[4] = '{1, 8'h3B, 8'h3B, 8'h3B, 8'h3B, 8'h00, 0, 0, 0, 8, 7};
        vt[5] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8, 0, 1, 8, 7};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            f1_t[i] = 8'h3B;
            f2_t[i] = 8'h3B;
        end
        @(negedge clk);
        chk_rst(0, "rst0");
        chk_rst(1, "rst1");
        chk_rst(2, "rst2");
        reset = 1'b0;
        @(negedge clk);
        chk_rst(0, "post_rst");

        for (int i = 0; i < 6; i++)
            sweep(vt[i].k, vt[i].f1, vt[i].f2, vt[i].t1, vt[i].t2,
                  vt[i].mm, vt[i].ec, vt[i].fe, vt[i].er, vt[i].lat,
                  vt[i].xyz, -1, $sformatf("vec%0d", i));

        // start re-pulsed at minterm 4 must not restart
        sweep(0, 8'h3B, 8'h3B, 8'h3B, 8'h3B, 8'h00, 0, 0, 0, 8, 7, 4,
              "repulse");

        // start held high: next sweep begins one edge after DONE cycle
        f1_t[0] = 8'h3B;
        f2_t[0] = 8'hFF;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        c = 0;
        while (c < 50 && !done_w[0]) begin
            @(negedge clk);
            c++;
        end
        chk("held.lat1", 32'(c), 8);
        chk("held.tt2_1", 32'(tt2_w[0]), 32'hFF);
        @(negedge clk);
        chk("held.idle_busy", 32'(busy_w[0]), 0);
        chk("held.idle_done", 32'(done_w[0]), 0);
        chk("held.idle_ec", 32'(ec_w[0]), 3);
        @(negedge clk);
        chk("held.restart_busy", 32'(busy_w[0]), 1);
        chk("held.clr_tt2", 32'(tt2_w[0]), 0);
        chk("held.clr_ec", 32'(ec_w[0]), 0);
        chk("held.clr_err", 32'(err_w[0]), 0);
        chk("held.xyz0", 32'(xyz(0)), 0);
        start_w[0] = 1'b0;
        c = 0;
        while (c < 50 && !done_w[0]) begin
            @(negedge clk);
            c++;
        end
        chk("held.lat2", 32'(c), 8);
        chk("held.ec2", 32'(ec_w[0]), 3);
        chk("held.mm2", 32'(mm_w[0]), 32'hC4);
        @(negedge clk);
        @(negedge clk);

        // asynchronous reset mid-sweep at minterm 5
        f2_t[0] = 8'h3B;
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        c = 0;
        while (c < 50 && xyz(0) != 3'd5) begin
            @(negedge clk);
            c++;
        end
        chk("arst.reach5", 32'(xyz(0)), 5);
        #2;
        reset = 1'b1;
        #1;
        chk_rst(0, "arst");
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) seen = 1'b1;
        end
        chk("arst.no_done", 32'(seen), 0);
        sweep(0, 8'h3B, 8'h3B, 8'h3B, 8'h3B, 8'h00, 0, 0, 0, 8, 7, -1,
              "arst_clean");

        // random truth tables against the model
        for (int r = 0; r < 20; r++) begin
            k = int'($urandom_range(0, 2));
            f1 = 8'($urandom);
            f2 = f1 ^ 8'($urandom & $urandom & $urandom);
            model(f1, f2, k == 1, t1, t2, ec, fe, e, nv);
            sweep(k, f1, f2, t1, t2, t1 ^ t2, ec, fe, e,
                  nv * ((k == 2) ? 3 : 1), nv - 1, -1,
                  $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
